// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side stream adapter: occupancy
// encoding, default data width and the read-latency legality check.
package fifo_pkg;

  // Occupancy of the head/skid output buffer.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  localparam int DATA_SIZE_DEF  = 8;
  localparam int RD_LATENCY_MAX = 1;

  // Only show-ahead (0) and registered (1) FIFO read ports are supported.
  function automatic bit rd_latency_ok(input int lat);
    return (lat >= 0) && (lat <= RD_LATENCY_MAX);
  endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry head/skid register pair. Captured words fill the head first;
// the skid only absorbs a word when the head is occupied and not leaving.
// Occupancy is exposed so the parent can derive valid and the issue rule.
module rd_skid_buf
  import fifo_pkg::*;
#(
  parameter int W = DATA_SIZE_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cap,
  input  logic [W-1:0] cap_data,
  input  logic         pop,
  output occ_e         occ,
  output logic [W-1:0] head
);

  occ_e         occ_q, occ_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] skid_q, skid_d;

  // State and storage registers; buffered words are discarded on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q  <= OCC_EMPTY;
      head_q <= '0;
      skid_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end

  // Next occupancy and data steering for every cap/pop combination.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    skid_d = skid_q;
    case (occ_q)
      OCC_EMPTY: begin
        if (cap) begin
          head_d = cap_data;
          occ_d  = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (cap && pop) begin
          head_d = cap_data;
        end else if (cap) begin
          skid_d = cap_data;
          occ_d  = OCC_TWO;
        end else if (pop) begin
          occ_d  = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        // The issue rule never lets a capture land here without a pop.
        if (pop) begin
          head_d = skid_q;
          if (cap) begin
            skid_d = cap_data;
          end else begin
            occ_d  = OCC_ONE;
          end
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
  end

  assign occ  = occ_q;
  assign head = head_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side adapter for the async FIFO: converts empty/rd_en/rd_data into a
// registered valid/ready stream through a 2-entry prefetch buffer.
// Handshake: a beat transfers on a cycle where o_valid and i_ready are both
// high; o_valid/o_data/o_last hold until that transfer happens.
// Optional feature macro: FIFO_RD_STREAM_LAST_EN adds the o_last frame tag.
// o_occ is a debug view of the buffer occupancy state.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE  = DATA_SIZE_DEF,
  parameter int RD_LATENCY = 0,
  parameter int FRAME_LEN  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_empty,
  output logic                 o_rd_en,
  input  logic [DATA_SIZE-1:0] i_rd_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [DATA_SIZE-1:0] o_data,
`ifdef FIFO_RD_STREAM_LAST_EN
  output logic                 o_last,
`endif
  output occ_e                 o_occ
);

  // Elaboration fails with a divide-by-zero on an unsupported latency.
  localparam int LAT_GUARD = 1 / int'(rd_latency_ok(RD_LATENCY));

`ifdef FIFO_RD_STREAM_LAST_EN
  localparam int TAG_W = 1;
`else
  localparam int TAG_W = 0;
`endif
  localparam int W = DATA_SIZE + TAG_W;

  occ_e         occ;
  logic         inflight;
  logic         cap;
  logic         pop;
  logic [2:0]   level;
  logic [W-1:0] cap_word;
  logic [W-1:0] head_word;

  assign o_valid = (occ != OCC_EMPTY);
  assign pop     = o_valid & i_ready;
  assign o_occ   = occ;

  // Issue a read only while the buffer plus in-flight beat stays within 2
  // entries after this cycle's pop; gated off during reset.
  assign level   = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign o_rd_en = i_rst_n & ~i_empty & (level < 3'd2);

  if (RD_LATENCY == 0 && LAT_GUARD == 1) begin : g_lat0
    // Show-ahead FIFO: data is on i_rd_data in the strobe cycle.
    assign inflight = 1'b0;
    assign cap      = o_rd_en;
  end else begin : g_lat1
    logic inflight_q;

    // Registered FIFO: data returns one cycle after the strobe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) inflight_q <= 1'b0;
      else          inflight_q <= o_rd_en;
    end

    assign inflight = inflight_q;
    assign cap      = inflight_q;
  end

`ifdef FIFO_RD_STREAM_LAST_EN
  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

  logic [CW-1:0] cnt_q;

  // Beat position within the frame, advanced on every captured beat.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                cnt_q <= '0;
    else if (cap && cnt_q == LAST_IDX) cnt_q <= '0;
    else if (cap)                cnt_q <= cnt_q + 1'b1;
  end

  assign cap_word = {(cnt_q == LAST_IDX), i_rd_data};
  assign o_last   = head_word[DATA_SIZE];
  assign o_data   = head_word[DATA_SIZE-1:0];
`else
  assign cap_word = i_rd_data;
  assign o_data   = head_word;
`endif

  rd_skid_buf #(
    .W (W)
  ) u_buf (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .cap      (cap),
    .cap_data (cap_word),
    .pop      (pop),
    .occ      (occ),
    .head     (head_word)
  );

endmodule
